vga_timing_ctrl: RTL
====================

# vga_timing_ctrl

VGA raster timing controller: sequences horizontal and vertical timing from a pixel-rate enable produced by an internal `enable_gen` divider. It produces sync pulses, the data-enable flag, pixel coordinates and a frame-start strobe for the pixel pipeline. It sits between the system clock domain and the pixel generator/RGB output stage. All logic runs on one clock and advances only on pixel-enable cycles.

## Interface
- `EN_BIT_SIZE`, default 1: divider width. The pixel enable fires once every 2^EN_BIT_SIZE clocks.
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_ACTIVE`, default 480: visible lines.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.
- `clk` input, 1 bit: the single clock.
- `i_sclr` input, 1 bit: synchronous, active-high reset/clear.
- `o_pix_en` output, 1 bit: pixel-rate enable, passed through from `enable_gen`.
- `o_hsync` output, 1 bit: horizontal sync, active low.
- `o_vsync` output, 1 bit: vertical sync, active low.
- `o_de` output, 1 bit: high when both axes are in ACTIVE.
- `o_x` output, 10 bits: horizontal counter, 0..H_TOTAL−1.
- `o_y` output, 10 bits: vertical counter, 0..V_TOTAL−1.
- `o_frame_start` output, 1 bit: one-clock strobe on wrap to (0,0).

## Operation
- Totals are derived values:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
  - Both totals must be ≤ 1024; this is checked by an elaboration-time assertion.
- Each axis has a 4-state FSM: ACTIVE → FP → SYNC → BP → ACTIVE.
  - A state is left when its segment length has elapsed.
  - The state always matches the counter: ACTIVE = [0, ACTIVE), FP = [ACTIVE, ACTIVE+FP), SYNC next, BP last.
- Horizontal axis:
  - Counter and FSM advance only on cycles where `o_pix_en` = 1.
  - On count H_TOTAL−1 the counter wraps to 0.
- Vertical axis:
  - Counter and FSM advance only on a `o_pix_en` cycle where the horizontal counter wraps.
  - On count V_TOTAL−1 the counter wraps to 0.
- Output derivation:
  - `o_hsync` = 0 exactly while H state is SYNC.
  - `o_vsync` = 0 exactly while V state is SYNC.
  - `o_de` = (H == ACTIVE) && (V == ACTIVE).
- `o_frame_start` = 1 for the single clock following the edge on which (x, y) wraps from (H_TOTAL−1, V_TOTAL−1) to (0, 0). It never fires on release from reset.
- Reset values (all outputs registered):
  - `o_x` = 0, `o_y` = 0.
  - Both FSMs = ACTIVE, so `o_de` = 1.
  - `o_hsync` = 1, `o_vsync` = 1.
  - `o_frame_start` = 0.
  - Divider counter = 0, so `o_pix_en` = 0.
- `i_sclr` has priority over everything. Reset mid-line or mid-frame returns all state to reset values on that edge and restarts the divider phase.

## Timing
- Divider:
  - `o_pix_en` first goes high on the (2^EN_BIT_SIZE − 1)-th rising edge after the clearing edge.
  - It then repeats every 2^EN_BIT_SIZE clocks and is high for 1 clock.
- Coordinate/sync update latency:
  - `o_x`, `o_y`, FSM outputs and syncs update on the edge where `o_pix_en` is sampled high.
  - They are visible the clock after that edge and hold for 2^EN_BIT_SIZE clocks.
- With EN_BIT_SIZE = 0, `o_pix_en` is constantly 1 after reset and the controller advances every clock.
- Frame period = H_TOTAL × V_TOTAL × 2^EN_BIT_SIZE clocks.

## Configuration
- Macro: `VGA_TIMING_FRAME_CNT_EN`.
- Defined:
  - Adds output `o_frame_cnt` [7:0].
  - Reset value is 0.
  - Increments on every `o_frame_start` strobe and wraps 255 → 0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `vga_pkg` holds:
  - The axis state encoding (ACTIVE/FP/SYNC/BP, 2 bits).
  - The 640×480@60 default timing constants.
  - The coordinate width constant (10).
- Sub-module: one `enable_gen` instance (BIT_SIZE = EN_BIT_SIZE, i_sclr shared) generates `o_pix_en`.
- Horizontal and vertical FSM/counter logic stays in this module, with both axes sharing a common next-state function from the package.

## Test plan
All scenarios use bench parameters EN_BIT_SIZE=1, H = 4/1/2/1 (H_TOTAL=8) and V = 3/1/1/1 (V_TOTAL=6).
- Reset: pulse `i_sclr` for 1 cycle → x=0, y=0, de=1, hsync=1, vsync=1, frame_start=0, pix_en=0.
  - First pix_en occurs 1 edge after clear, then every 2 clocks.
- Line sweep: across 8 pix_en cycles →
  - x = 0..7, with de=1 for x 0–3 and de=0 for x 4–7.
  - hsync=0 only for x 5–6.
  - Then x=0, y=1.
- Frame sweep: over 48 pix_en cycles →
  - vsync=0 only for y=4.
  - de=0 for all y ≥ 3.
  - frame_start high for exactly 1 clock, 96 clocks apart, only at the (7,5)→(0,0) wrap.
- Mid-frame reset: assert `i_sclr` at x=2, y=4 (vsync low) → the next clock shows the reset values, vsync returns to 1, and the divider phase restarts.
- EN_BIT_SIZE=0 variant: pix_en constantly 1 and x increments every clock; frame period is 48 clocks.
- `VGA_TIMING_FRAME_CNT_EN` defined: `o_frame_cnt` counts 0→1→2 across 3 frames; preloaded at 255, it wraps to 0 on the next frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Purpose: shared definitions for the VGA raster timing controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: none; the raster free-runs off the pixel enable.
// Contents: axis state encoding, 640x480@60 default timing, coordinate width,
//           and the next-state function used by both the horizontal and vertical axes.
package vga_pkg;

  localparam int COORD_W = 10;

  // 640x480@60 defaults
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FP     = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BP     = 2'd3
  } axis_st_e;

  // Next state for one axis given its current state and the counter value it
  // is about to take. A segment is left exactly when the counter reaches its
  // end boundary, so the state always tracks the counter range it describes.
  // Every segment must be at least one unit long for this to hold.
  function automatic axis_st_e axis_next_state(
    input axis_st_e             st,
    input logic [COORD_W-1:0]   cnt_n,
    input int                   act,
    input int                   fp,
    input int                   sync
  );
    int       c;
    axis_st_e nxt;
    c   = int'(cnt_n);
    nxt = st;
    unique case (st)
      ST_ACTIVE: if (c == act)             nxt = ST_FP;
      ST_FP:     if (c == act + fp)        nxt = ST_SYNC;
      ST_SYNC:   if (c == act + fp + sync) nxt = ST_BP;
      default:   if (c == 0)               nxt = ST_ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_enable_gen.sv
// Purpose: pixel-rate enable divider, one-clock pulse every 2^BIT_SIZE clocks.
// Latency: first pulse registered on the (2^BIT_SIZE - 1)-th edge after clear.
// Backpressure: none; free-running.
// Ports: clk, i_sclr (sync active-high clear, restarts the phase), o_en (registered pulse).
module enable_gen #(
  parameter int BIT_SIZE = 1
) (
  input  logic clk,
  input  logic i_sclr,
  output logic o_en
);

  if (BIT_SIZE == 0) begin : g_every
    logic en_q, en_d;

    always_comb begin
      en_d = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (i_sclr) en_q <= 1'b0;
      else        en_q <= en_d;
    end

    assign o_en = en_q;
  end else begin : g_div
    logic [BIT_SIZE-1:0] cnt_q, cnt_d;
    logic                en_q, en_d;

    // Pulse is registered together with the count reaching all-ones.
    always_comb begin
      cnt_d = cnt_q + BIT_SIZE'(1);
      en_d  = &cnt_d;
    end

    always_ff @(posedge clk) begin
      if (i_sclr) begin
        cnt_q <= '0;
        en_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        en_q  <= en_d;
      end
    end

    assign o_en = en_q;
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Purpose: VGA raster timing (syncs, data enable, x/y, frame strobe) advanced by a pixel enable.
// Latency: all outputs registered; they update on the edge where o_pix_en is sampled high.
// Backpressure: none; free-running raster. Optional VGA_TIMING_FRAME_CNT_EN adds o_frame_cnt.
// Ports: clk, i_sclr (sync active-high clear) -> o_pix_en, o_hsync/o_vsync (active low),
//        o_de, o_x, o_y, o_frame_start [, o_frame_cnt].
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int EN_BIT_SIZE = 1,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF
) (
  input  logic               clk,
  input  logic               i_sclr,
  output logic               o_pix_en,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]         o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
    $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  logic pix_en;

  enable_gen #(
    .BIT_SIZE (EN_BIT_SIZE)
  ) u_enable_gen (
    .clk    (clk),
    .i_sclr (i_sclr),
    .o_en   (pix_en)
  );

  assign o_pix_en = pix_en;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  axis_st_e           hst_q, hst_d, vst_q, vst_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic               h_wrap, v_wrap;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    fs_d   = 1'b0;
    h_wrap = (x_q == H_LAST);
    v_wrap = (y_q == V_LAST);
    if (pix_en) begin
      x_d = h_wrap ? '0 : x_q + COORD_W'(1);
      // Vertical axis moves only on the pixel that ends a line.
      if (h_wrap) begin
        y_d  = v_wrap ? '0 : y_q + COORD_W'(1);
        fs_d = v_wrap;
      end
    end
    hst_d = axis_next_state(hst_q, x_d, H_ACTIVE, H_FP, H_SYNC);
    vst_d = axis_next_state(vst_q, y_d, V_ACTIVE, V_FP, V_SYNC);
    // Outputs are decoded from the next state so they register in step with it.
    hs_d  = (hst_d != ST_SYNC);
    vs_d  = (vst_d != ST_SYNC);
    de_d  = (hst_d == ST_ACTIVE) && (vst_d == ST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      x_q   <= '0;
      y_q   <= '0;
      hst_q <= ST_ACTIVE;
      vst_q <= ST_ACTIVE;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      hst_q <= hst_d;
      vst_q <= vst_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      fs_q  <= fs_d;
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_hsync       = hs_q;
  assign o_vsync       = vs_q;
  assign o_de          = de_q;
  assign o_frame_start = fs_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;

  // Counts on the same edge that registers the strobe, so the new count
  // appears together with o_frame_start; wraps naturally at 8 bits.
  always_comb begin
    fcnt_d = fs_d ? fcnt_q + 8'd1 : fcnt_q;
  end

  always_ff @(posedge clk) begin
    if (i_sclr) fcnt_q <= 8'd0;
    else        fcnt_q <= fcnt_d;
  end

  assign o_frame_cnt = fcnt_q;
`else
  // No frame counter in this build.
`endif

endmodule
